// File: rtl/joust2_rom_loader.sv
// joust2_rom_loader: bridges the HPS ioctl byte stream to the williams2 ROM
// write port. Each byte is decoded into a ROM region and handed to the core
// over a req/ack handshake while ioctl_wait stalls the HPS. Reports load
// completion, byte count and integrity errors.
// Optional feature macro: JOUST2_ROM_CHKSUM_EN adds the 8-bit additive
// checksum and makes it part of the end-of-load evaluation.
module joust2_rom_loader #(
   parameter logic [7:0]  ROM_INDEX    = 8'd0,
   parameter logic [17:0] EXPECTED_LEN = 18'h1C000,
   parameter logic [16:0] SND_BASE     = 17'h0C000,
   parameter logic [16:0] GFX_BASE     = 17'h10000,
   parameter logic [7:0]  ACK_TIMEOUT  = 8'd255
`ifdef JOUST2_ROM_CHKSUM_EN
  ,parameter logic [7:0]  EXPECTED_SUM = 8'h00
`endif
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [16:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [16:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic [1:0]  rom_region,
   output logic        rom_we,
   input  logic        rom_ack,
   output logic        load_active,
   output logic        load_done,
   output logic        load_error,
   output logic [17:0] byte_count,
   output logic [7:0]  checksum
);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WRITE, S_DONE, S_ERROR} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_dl_prev, r_end_pend, r_sticky;
   logic [7:0]  r_to_cnt;
   logic [16:0] r_rom_addr;
   logic [7:0]  r_rom_data;
   logic [1:0]  r_rom_region;
   logic        r_rom_we, r_wait, r_active, r_done, r_error;
   logic [17:0] r_count;

   logic        w_rise, w_fall, w_arm, w_capture, w_accept;
   logic        w_sum_ok_armed, w_sum_ok_ack;
   logic [17:0] w_count_inc;
   logic [1:0]  w_region;
   logic [16:0] w_rel_addr;

   // Only downloads on our slot can arm the loader; any falling edge ends a load.
   assign w_rise      = ioctl_download & ~r_dl_prev & (ioctl_index == ROM_INDEX);
   assign w_fall      = ~ioctl_download & r_dl_prev;
   assign w_count_inc = (r_count == 18'h3FFFF) ? r_count : r_count + 18'd1;

   // Address decode into program / sound / graphics regions.
   always_comb begin
      w_region   = 2'd0;
      w_rel_addr = ioctl_addr;
      if (ioctl_addr < SND_BASE) begin
         w_region   = 2'd0;
         w_rel_addr = ioctl_addr;
      end else if (ioctl_addr < GFX_BASE) begin
         w_region   = 2'd1;
         w_rel_addr = ioctl_addr - SND_BASE;
      end else begin
         w_region   = 2'd2;
         w_rel_addr = ioctl_addr - GFX_BASE;
      end
   end

   // Next-state logic; evaluation on ack uses the post-increment count so a
   // download ending mid-write is judged on the completed byte.
   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (w_rise) begin
               w_state_nxt = S_ARMED;
               w_arm       = 1'b1;
            end
         end
         S_ARMED: begin
            if (w_fall) begin
               w_state_nxt = ((r_count == EXPECTED_LEN) && !r_sticky && w_sum_ok_armed)
                             ? S_DONE : S_ERROR;
            end else if (ioctl_wr) begin
               w_state_nxt = S_WRITE;
               w_capture   = 1'b1;
            end
         end
         S_WRITE: begin
            if (rom_ack) begin
               w_accept = 1'b1;
               if (r_end_pend || w_fall) begin
                  w_state_nxt = ((w_count_inc == EXPECTED_LEN) && !r_sticky && !ioctl_wr &&
                                 w_sum_ok_ack) ? S_DONE : S_ERROR;
               end else begin
                  w_state_nxt = S_ARMED;
               end
            end else if (r_to_cnt == ACK_TIMEOUT - 8'd1) begin
               w_state_nxt = S_ERROR;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and download-line edge history.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_dl_prev <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dl_prev <= ioctl_download;
      end
   end

   // Byte capture: hold address, data and region for the whole handshake.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_rom_addr   <= '0;
         r_rom_data   <= '0;
         r_rom_region <= '0;
      end else if (w_capture) begin
         r_rom_addr   <= w_rel_addr;
         r_rom_data   <= ioctl_dout;
         r_rom_region <= w_region;
      end
   end

   // Integrity tracking: address gaps and overruns are sticky; a download
   // ending during a write is remembered until the write completes.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_sticky   <= 1'b0;
         r_end_pend <= 1'b0;
      end else if (w_arm) begin
         r_sticky   <= 1'b0;
         r_end_pend <= 1'b0;
      end else begin
         if (w_capture && (ioctl_addr != r_count[16:0])) r_sticky <= 1'b1;
         if ((r_state == S_WRITE) && ioctl_wr)           r_sticky <= 1'b1;
         if (w_capture)                                  r_end_pend <= 1'b0;
         else if ((r_state == S_WRITE) && w_fall)        r_end_pend <= 1'b1;
      end
   end

   // Ack timeout counter, zeroed on each WRITE entry.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                r_to_cnt <= '0;
      else if (w_capture)          r_to_cnt <= '0;
      else if (r_state == S_WRITE) r_to_cnt <= r_to_cnt + 8'd1;
   end

   // Saturating count of acknowledged bytes.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)      r_count <= '0;
      else if (w_arm)    r_count <= '0;
      else if (w_accept) r_count <= w_count_inc;
   end

`ifdef JOUST2_ROM_CHKSUM_EN
   logic [7:0] r_sum;
   logic [7:0] w_sum_inc;
   assign w_sum_inc      = r_sum + r_rom_data;
   assign w_sum_ok_armed = (r_sum == EXPECTED_SUM);
   assign w_sum_ok_ack   = (w_sum_inc == EXPECTED_SUM);
   assign checksum       = r_sum;

   // Running mod-256 sum of acknowledged bytes.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)      r_sum <= '0;
      else if (w_arm)    r_sum <= '0;
      else if (w_accept) r_sum <= w_sum_inc;
   end
`else
   assign w_sum_ok_armed = 1'b1;
   assign w_sum_ok_ack   = 1'b1;
   assign checksum       = 8'h00;
`endif

   // Registered handshake and status outputs derived from the next state.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_rom_we <= 1'b0;
         r_wait   <= 1'b0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_rom_we <= (w_state_nxt == S_WRITE);
         r_wait   <= (w_state_nxt == S_WRITE);
         r_active <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_WRITE);
         if (w_arm) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
         end else begin
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE))   r_done  <= 1'b1;
            if ((w_state_nxt == S_ERROR) && (r_state != S_ERROR)) r_error <= 1'b1;
         end
      end
   end

   assign ioctl_wait  = r_wait;
   assign rom_addr    = r_rom_addr;
   assign rom_data    = r_rom_data;
   assign rom_region  = r_rom_region;
   assign rom_we      = r_rom_we;
   assign load_active = r_active;
   assign load_done   = r_done;
   assign load_error  = r_error;
   assign byte_count  = r_count;

endmodule

// File: tb/tb_joust2_rom_loader.sv
// Directed testbench for joust2_rom_loader. The image length is shortened
// to 256 bytes so full-length loads stay short.
module tb_joust2_rom_loader;

   localparam logic [17:0] TB_LEN = 18'd256;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [16:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [16:0] rom_addr;
   logic [7:0]  rom_data;
   logic [1:0]  rom_region;
   logic        rom_we;
   logic        rom_ack;
   logic        load_active;
   logic        load_done;
   logic        load_error;
   logic [17:0] byte_count;
   logic [7:0]  checksum;

   int errors = 0;
   int checks = 0;

   always #5 clk_sys = ~clk_sys;

   joust2_rom_loader #(.EXPECTED_LEN(TB_LEN)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_region(rom_region), .rom_we(rom_we),
      .rom_ack(rom_ack), .load_active(load_active), .load_done(load_done),
      .load_error(load_error), .byte_count(byte_count), .checksum(checksum)
   );

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      @(negedge clk_sys);
   endtask

   // One byte with ack returned the cycle after rom_we (best-case pacing).
   task automatic send_byte(input logic [16:0] a, input logic [7:0] d,
                            output logic [1:0] reg_o, output logic [16:0] addr_o,
                            output logic [7:0] data_o, output logic we_o,
                            output logic wait_o);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      reg_o    = rom_region;
      addr_o   = rom_addr;
      data_o   = rom_data;
      we_o     = rom_we;
      wait_o   = ioctl_wait;
      @(negedge clk_sys);
      rom_ack = 1'b1;
      @(negedge clk_sys);
      rom_ack = 1'b0;
   endtask

   task automatic send(input logic [16:0] a, input logic [7:0] d);
      logic [1:0] r; logic [16:0] ad; logic [7:0] dt; logic w, wt;
      send_byte(a, d, r, ad, dt, w, wt);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; rom_ack = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++; if (ioctl_wait !== 1'b0)  begin errors++; $display("FAIL reset_wait got=%b exp=0", ioctl_wait); end
      checks++; if (rom_we !== 1'b0)      begin errors++; $display("FAIL reset_we got=%b exp=0", rom_we); end
      checks++; if ({rom_addr, rom_data, rom_region} !== 27'd0)
         begin errors++; $display("FAIL reset_rom got=%h/%h/%h exp=0", rom_addr, rom_data, rom_region); end
      checks++; if ({load_active, load_done, load_error} !== 3'b000)
         begin errors++; $display("FAIL reset_status got=%b exp=000", {load_active, load_done, load_error}); end
      checks++; if (byte_count !== 18'd0 || checksum !== 8'd0)
         begin errors++; $display("FAIL reset_counts got=%h/%h exp=0/0", byte_count, checksum); end
      reset_n = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic test_region_decode();
      logic [1:0] r; logic [16:0] a; logic [7:0] d; logic w, wt;
      start_dl(8'd0);
      send_byte(17'h0BFFF, 8'h11, r, a, d, w, wt);
      checks++; if (r !== 2'd0 || a !== 17'h0BFFF)
         begin errors++; $display("FAIL region_prog got=%0d/%h exp=0/0bfff", r, a); end
      send_byte(17'h0C000, 8'h22, r, a, d, w, wt);
      checks++; if (r !== 2'd1 || a !== 17'h00000)
         begin errors++; $display("FAIL region_snd got=%0d/%h exp=1/00000", r, a); end
      send_byte(17'h10005, 8'h33, r, a, d, w, wt);
      checks++; if (r !== 2'd2 || a !== 17'h00005 || d !== 8'h33)
         begin errors++; $display("FAIL region_gfx got=%0d/%h/%h exp=2/00005/33", r, a, d); end
      end_dl();
      checks++; if (load_error !== 1'b1 || load_done !== 1'b0)
         begin errors++; $display("FAIL region_end got=err%b done%b exp=err1 done0", load_error, load_done); end
   endtask

   task automatic test_clean_load();
      logic [1:0] r; logic [16:0] a; logic [7:0] d; logic w, wt;
      start_dl(8'd0);
      checks++; if (load_active !== 1'b1 || load_error !== 1'b0)
         begin errors++; $display("FAIL arm_clear got=act%b err%b exp=act1 err0", load_active, load_error); end
      send_byte(17'd0, 8'h01, r, a, d, w, wt);
      checks++; if (w !== 1'b1 || wt !== 1'b1 || d !== 8'h01)
         begin errors++; $display("FAIL capture_latency got=we%b wait%b data%h exp=we1 wait1 data01", w, wt, d); end
      checks++; if (ioctl_wait !== 1'b0 || byte_count !== 18'd1)
         begin errors++; $display("FAIL ack_release got=wait%b cnt%0d exp=wait0 cnt1", ioctl_wait, byte_count); end
      for (int i = 1; i < 256; i++) send(17'(i), 8'h01);
      end_dl();
      checks++; if (load_done !== 1'b1 || load_error !== 1'b0)
         begin errors++; $display("FAIL clean_status got=done%b err%b exp=done1 err0", load_done, load_error); end
      checks++; if (byte_count !== TB_LEN || checksum !== 8'h00)
         begin errors++; $display("FAIL clean_counts got=%h/%h exp=%h/00", byte_count, checksum, TB_LEN); end
      checks++; if (load_active !== 1'b0)
         begin errors++; $display("FAIL clean_active got=%b exp=0", load_active); end
   endtask

   task automatic test_back_pressure();
      int bad = 0;
      start_dl(8'd0);
      ioctl_wr = 1'b1; ioctl_addr = 17'd0; ioctl_dout = 8'hA5;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (!(ioctl_wait === 1'b1 && rom_we === 1'b1 && byte_count === 18'd0 && rom_data === 8'hA5)) bad++;
         if (c == 3) begin ioctl_wr = 1'b1; ioctl_addr = 17'd1; ioctl_dout = 8'h77; end
         else ioctl_wr = 1'b0;
         @(negedge clk_sys);
      end
      checks++; if (bad !== 0)
         begin errors++; $display("FAIL backpressure_hold got=%0d bad cycles exp=0", bad); end
      rom_ack = 1'b1;
      @(negedge clk_sys);
      rom_ack = 1'b0;
      checks++; if (byte_count !== 18'd1 || ioctl_wait !== 1'b0)
         begin errors++; $display("FAIL backpressure_ack got=cnt%0d wait%b exp=cnt1 wait0", byte_count, ioctl_wait); end
      for (int i = 1; i < 256; i++) send(17'(i), 8'h00);
      end_dl();
      checks++; if (load_error !== 1'b1 || load_done !== 1'b0 || byte_count !== TB_LEN)
         begin errors++; $display("FAIL overrun_end got=err%b done%b cnt%0d exp=err1 done0 cnt256", load_error, load_done, byte_count); end
   endtask

   task automatic test_timeout();
      start_dl(8'd0);
      ioctl_wr = 1'b1; ioctl_addr = 17'd0; ioctl_dout = 8'h5A;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      repeat (254) @(negedge clk_sys);
      checks++; if (rom_we !== 1'b1 || ioctl_wait !== 1'b1)
         begin errors++; $display("FAIL timeout_early got=we%b wait%b exp=we1 wait1", rom_we, ioctl_wait); end
      @(negedge clk_sys);
      checks++; if (rom_we !== 1'b0 || load_error !== 1'b1 || load_active !== 1'b0 || ioctl_wait !== 1'b0)
         begin errors++; $display("FAIL timeout_error got=we%b err%b act%b wait%b exp=we0 err1 act0 wait0",
                                  rom_we, load_error, load_active, ioctl_wait); end
      end_dl();
   endtask

   task automatic test_short_load();
      start_dl(8'd0);
      for (int i = 0; i < 100; i++) send(17'(i), 8'h02);
      end_dl();
      checks++; if (load_error !== 1'b1 || load_done !== 1'b0 || byte_count !== 18'd100)
         begin errors++; $display("FAIL short_load got=err%b done%b cnt%0d exp=err1 done0 cnt100", load_error, load_done, byte_count); end
   endtask

   task automatic test_skipped_addr();
      start_dl(8'd0);
      for (int i = 0; i < 256; i++) send((i < 5) ? 17'(i) : 17'(i + 1), 8'h01);
      end_dl();
      checks++; if (load_error !== 1'b1 || load_done !== 1'b0 || byte_count !== TB_LEN)
         begin errors++; $display("FAIL skip_addr got=err%b done%b cnt%0d exp=err1 done0 cnt256", load_error, load_done, byte_count); end
   endtask

   task automatic test_reset_foreign();
      start_dl(8'd0);
      ioctl_wr = 1'b1; ioctl_addr = 17'h10003; ioctl_dout = 8'h3C;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      checks++; if (rom_we !== 1'b1 || rom_region !== 2'd2 || rom_addr !== 17'h00003)
         begin errors++; $display("FAIL pre_reset got=we%b reg%0d addr%h exp=we1 reg2 addr00003", rom_we, rom_region, rom_addr); end
      #2;
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      #1;
      checks++; if (rom_we !== 1'b0 || ioctl_wait !== 1'b0 || load_active !== 1'b0)
         begin errors++; $display("FAIL async_reset got=we%b wait%b act%b exp=000", rom_we, ioctl_wait, load_active); end
      checks++; if ({rom_addr, rom_data, rom_region} !== 27'd0 || byte_count !== 18'd0)
         begin errors++; $display("FAIL async_reset_data got=%h/%h/%h cnt%0d exp=0", rom_addr, rom_data, rom_region, byte_count); end
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      start_dl(8'd1);
      ioctl_wr = 1'b1; ioctl_addr = 17'd0; ioctl_dout = 8'h99;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      checks++; if (ioctl_wait !== 1'b0 || rom_we !== 1'b0 || load_active !== 1'b0)
         begin errors++; $display("FAIL foreign_index got=wait%b we%b act%b exp=000", ioctl_wait, rom_we, load_active); end
      end_dl();
      checks++; if (load_done !== 1'b0 || load_error !== 1'b0 || byte_count !== 18'd0)
         begin errors++; $display("FAIL foreign_end got=done%b err%b cnt%0d exp=0/0/0", load_done, load_error, byte_count); end
   endtask

   initial begin
      test_reset();
      test_region_decode();
      test_clean_load();
      test_back_pressure();
      test_timeout();
      test_short_load();
      test_skipped_addr();
      test_reset_foreign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
